adder_share_arbiter: RTL and testbench

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

---
 rtl/adder_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: two requesters share one 32-bit ripple-carry adder, round-robin on ties.
// Latency: resp_valid rises SETTLE_CYCLES rising edges after the request-acceptance edge.
// Backpressure: result is held in RESP until resp_ready; requests stay pending (ready low) while busy.
// Optional feature: define ADDER_ARB_OVF_EN to add the resp_ovf signed-overflow output.

// ripple_carry_adder_32bit: plain 32-stage full-adder chain, purely combinational.
// Latency: combinational; the ripple path needs the owner to hold operands stable long enough.
// Backpressure: none (no handshake).
module ripple_carry_adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [32:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[32];
endmodule

// adder_share_arbiter: arbitrates two add requesters onto one shared adder, one transaction at a time.
// Latency: SETTLE_CYCLES edges from acceptance to resp_valid; one idle cycle after each response.
// Backpressure: RESP holds resp_* until resp_ready; reqN_ready only asserted in IDLE.
module adder_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        resp_cout,
`ifdef ADDER_ARB_OVF_EN
    output logic        resp_ovf,
`endif
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Settle counter starts at SETTLE_CYCLES-1 and captures when it reaches zero.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;        // requester granted most recently
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        op_cin_q, op_cin_d;
    logic        op_id_q, op_id_d;
    logic [31:0] resp_sum_q, resp_sum_d;
    logic        resp_cout_q, resp_cout_d;
    logic        resp_id_q, resp_id_d;
`ifdef ADDER_ARB_OVF_EN
    logic        resp_ovf_q, resp_ovf_d;
`endif

    logic        win;
    logic [31:0] add_sum;
    logic        add_cout;

    // The only adder; it sees nothing but the latched operand registers.
    ripple_carry_adder_32bit u_adder (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .cin_i  (op_cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Next-state, arbitration and operand/result capture decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        resp_sum_d  = resp_sum_q;
        resp_cout_d = resp_cout_q;
        resp_id_d   = resp_id_q;
`ifdef ADDER_ARB_OVF_EN
        resp_ovf_d  = resp_ovf_q;
`endif
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        // Tie goes to the requester not granted last; a lone valid always wins.
        if (req0_valid && req1_valid) begin
            win = ~ptr_q;
        end else begin
            win = req1_valid;
        end

        case (state_q)
            IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready = ~win;
                    req1_ready = win;
                    op_a_d     = win ? req1_a   : req0_a;
                    op_b_d     = win ? req1_b   : req0_b;
                    op_cin_d   = win ? req1_cin : req0_cin;
                    op_id_d    = win;
                    ptr_d      = win;
                    cnt_d      = CNT_LOAD;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    resp_sum_d  = add_sum;
                    resp_cout_d = add_cout;
                    resp_id_d   = op_id_q;
`ifdef ADDER_ARB_OVF_EN
                    resp_ovf_d  = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ptr_q       <= 1'b1;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            op_cin_q    <= 1'b0;
            op_id_q     <= 1'b0;
            resp_sum_q  <= 32'd0;
            resp_cout_q <= 1'b0;
            resp_id_q   <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
            resp_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            resp_sum_q  <= resp_sum_d;
            resp_cout_q <= resp_cout_d;
            resp_id_q   <= resp_id_d;
`ifdef ADDER_ARB_OVF_EN
            resp_ovf_q  <= resp_ovf_d;
`endif
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
`ifdef ADDER_ARB_OVF_EN
    assign resp_ovf   = resp_ovf_q;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed cases plus randomized traffic from both requesters.
// Expected results are pushed at acceptance and compared by a negedge monitor while resp_valid is high.
// The monitor also tracks grant fairness, busy and ready behaviour from its own abstract model.
module tb_adder_share_arbiter;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld [2];
    logic [31:0] opa [2];
    logic [31:0] opb [2];
    logic        cin [2];
    logic        rdy0, rdy1;
    logic        resp_valid, resp_ready, resp_id, resp_cout, busy;
    logic [31:0] resp_sum;
`ifdef ADDER_ARB_OVF_EN
    logic        resp_ovf;
`endif

    typedef struct {
        logic        id;
        logic [32:0] res;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t expq[$];
    int   glog[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   m_busy = 0;
    int   m_last = 1;
    bit   prev_rv = 0;

    adder_share_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (vld[0]),
        .req0_ready (rdy0),
        .req0_a     (opa[0]),
        .req0_b     (opb[0]),
        .req0_cin   (cin[0]),
        .req1_valid (vld[1]),
        .req1_ready (rdy1),
        .req1_a     (opa[1]),
        .req1_b     (opb[1]),
        .req1_cin   (cin[1]),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
`ifdef ADDER_ARB_OVF_EN
        .resp_ovf   (resp_ovf),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout/unexpected event expected none (cycle %0d)", nm, cyc);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rdy0", rdy0, 0);
            chk("rst_rdy1", rdy1, 0);
            chk("rst_resp_valid", resp_valid, 0);
            expq.delete();
            m_busy  = 0;
            m_last  = 1;
            prev_rv = 0;
        end else begin
            chk("busy", busy, m_busy);
            if (!m_busy && (vld[0] || vld[1])) begin
                int w;
                w = (vld[0] && vld[1]) ? (1 - m_last) : (vld[0] ? 0 : 1);
                chk("grant_rdy0", rdy0, w == 0);
                chk("grant_rdy1", rdy1, w == 1);
            end else begin
                chk("idle_rdy0", rdy0, 0);
                chk("idle_rdy1", rdy1, 0);
            end
            for (int i = 0; i < 2; i++) begin
                if (vld[i] && ((i == 0) ? rdy0 : rdy1)) begin
                    exp_t e;
                    e.id  = i[0];
                    e.res = {1'b0, opa[i]} + {1'b0, opb[i]} + {32'd0, cin[i]};
                    e.ovf = (opa[i][31] == opb[i][31]) && (e.res[31] != opa[i][31]);
                    e.due = cyc + 1 + S;
                    expq.push_back(e);
                    glog.push_back(i);
                    m_last = i;
                    m_busy = 1;
                end
            end
            if (expq.size() > 0 && cyc == expq[0].due)
                chk("latency_valid", resp_valid, 1);
            if (resp_valid) begin
                if (expq.size() == 0) begin
                    fail_now("spurious_resp");
                end else begin
                    if (!prev_rv) chk("rise_cycle", cyc, expq[0].due);
                    chk("resp_id", resp_id, expq[0].id);
                    chk("resp_sum", resp_sum, expq[0].res[31:0]);
                    chk("resp_cout", resp_cout, expq[0].res[32]);
`ifdef ADDER_ARB_OVF_EN
                    chk("resp_ovf", resp_ovf, expq[0].ovf);
`endif
                    if (resp_ready) begin
                        void'(expq.pop_front());
                        m_busy = 0;
                    end
                end
            end
            prev_rv = resp_valid;
        end
    end

    task automatic wait_accept(input int id);
        int t = 0;
        forever begin
            @(negedge clk);
            if (vld[id] && ((id == 0) ? rdy0 : rdy1)) break;
            t++;
            if (t > 500) begin
                fail_now("accept_timeout");
                break;
            end
        end
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(posedge clk); #1;
        opa[id] = a; opb[id] = b; cin[id] = c; vld[id] = 1'b1;
        wait_accept(id);
        @(posedge clk); #1;
        vld[id] = 1'b0;
        opa[id] = $urandom; opb[id] = $urandom; cin[id] = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (expq.size() > 0) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'hFFFFFFFF;
            1: pick = 32'h7FFFFFFF;
            2: pick = 32'h80000000;
            3: pick = 32'h00000000;
            default: pick = $urandom;
        endcase
    endfunction

    task automatic drive_rand(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(id, pick(), pick(), 1'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1);
    end

    initial begin
        bit done;
        int t;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0; opa[i] = 0; opb[i] = 0; cin[i] = 0;
        end
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", resp_sum, 0);
        chk("rst_cout", resp_cout, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Tie fairness right out of reset: 0,1,0,1
        resp_ready = 1'b1;
        glog.delete();
        opa[0] = 1; opb[0] = 2; cin[0] = 0;
        opa[1] = 3; opb[1] = 4; cin[1] = 0;
        vld[0] = 1; vld[1] = 1;
        t = 0;
        while (glog.size() < 4 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        vld[0] = 0; vld[1] = 0;
        if (glog.size() < 4) fail_now("tie_timeout");
        else for (int i = 0; i < 4; i++) chk("tie_order", glog[i], i % 2);
        drain();

        // Single request and wrap-around
        send(0, 32'h00000001, 32'h00000001, 1'b0);
        drain();
        send(1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        drain();
        send(0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        drain();

        // Back-pressure with a pending requester waiting behind it
        resp_ready = 1'b0;
        send(0, 32'h12345678, 32'h11111111, 1'b1);
        opa[1] = 32'hDEADBEEF; opb[1] = 32'h01010101; cin[1] = 0; vld[1] = 1;
        t = 0;
        while (!resp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) fail_now("bp_valid_timeout");
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_sum", resp_sum, 32'h23456789 + 32'h1);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_accept(1);
        @(posedge clk); #1;
        vld[1] = 0;
        drain();

        // Randomized traffic from both sides with random consumer stalls
        done = 0;
        fork
            begin
                fork
                    drive_rand(0, 40);
                    drive_rand(1, 40);
                join
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        resp_ready = 1'b1;
        drain();

        // Reset while the adder is settling
        send(1, 32'hAAAA5555, 32'h5555AAAA, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", resp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", resp_sum, 0);
        chk("midrst_rdy0", rdy0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_quiet", resp_valid, 0);
        send(0, 32'h00000010, 32'h00000020, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
